// File: rtl/select_pkg.sv
// Shared constants and helpers for the two-requester select-mux arbiter.
// State encodings are plain constants so older blocks can reuse them unchanged.
package select_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G1   = 2'd1;
    localparam logic [1:0] G2   = 2'd2;

    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    // Identity of the most recently granted requester
    localparam logic [1:0] LAST_R1 = 2'd1;
    localparam logic [1:0] LAST_R2 = 2'd2;

    typedef struct packed {
        logic gnt1;
        logic gnt2;
        logic cntrl;
        logic busy;
    } arb_out_t;

    // On a simultaneous request the side that was not served last wins
    function automatic logic [1:0] tie_winner(input logic [1:0] last);
        return (last == LAST_R1) ? G2 : G1;
    endfunction

    function automatic logic [1:0] grant_state(input int idx);
        return (idx == 0) ? G1 : G2;
    endfunction

    function automatic logic state_sel(input logic [1:0] st, input logic park);
        logic sel;
        case (st)
            G1:      sel = SEL_IN1;
            G2:      sel = SEL_IN2;
            default: sel = park;
        endcase
        return sel;
    endfunction

    function automatic logic [1:0] last_for_state(input logic [1:0] st,
                                                  input logic [1:0] prev);
        logic [1:0] res;
        case (st)
            G1:      res = LAST_R1;
            G2:      res = LAST_R2;
            default: res = prev;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/select_arbiter_hold_counter.sv
// Saturating hold-time counter: counts contended grant cycles and flags when
// the current owner has used its last allowed cycle.
module hold_counter
    import select_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int              TERM_VAL = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TERM_VAL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             HOLD_ON  = (MAX_HOLD > 0);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             at_term;

    assign at_term = (cnt_reg == TERM_CNT);

    // Stops at the terminal value instead of wrapping; with MAX_HOLD=0 it never moves
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en && HOLD_ON && !at_term) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign term = HOLD_ON && at_term;

endmodule

// File: rtl/select_arbiter.sv
// Round-robin owner of the shared 2:1 select mux: grants one requester at a
// time, drives cntrl directly, and bounds the hold time under contention.
module select_arbiter
    import select_pkg::*;
#(
    parameter int   MAX_HOLD = 4,
    parameter logic PARK_SEL = 1'b0,
    parameter int   CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req1,
    input  logic req2,
    output logic gnt1,
    output logic gnt2,
    output logic cntrl,
    output logic busy
);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [1:0] last_reg;
    logic [1:0] last_next;
    logic       cntrl_reg;
    logic       busy_reg;

    logic       hold_term;
    logic       hold_clr;
    logic       hold_en;
    logic       preempt;
    logic       other_req;
    logic [1:0] gnt_vec;

    assign preempt = (MAX_HOLD != 0) && hold_term;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req1 && req2) begin
                    state_next = tie_winner(last_reg);
                end else if (req1) begin
                    state_next = G1;
                end else if (req2) begin
                    state_next = G2;
                end
            end
            G1: begin
                if (!req1) begin
                    state_next = req2 ? G2 : IDLE;
                end else if (req2 && preempt) begin
                    state_next = G2;
                end
            end
            G2: begin
                if (!req2) begin
                    state_next = req1 ? G1 : IDLE;
                end else if (req1 && preempt) begin
                    state_next = G1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter only tracks time spent by the current owner while the other side waits
    always_comb begin
        other_req = 1'b0;
        case (state_reg)
            G1:      other_req = req2;
            G2:      other_req = req1;
            default: other_req = 1'b0;
        endcase
    end

    assign hold_clr = (state_next != state_reg) || (state_next == IDLE);
    assign hold_en  = other_req;

    always_comb begin
        last_next = last_reg;
        if (state_next != state_reg) begin
            last_next = last_for_state(state_next, last_reg);
        end
    end

    hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hold_clr),
        .en    (hold_en),
        .term  (hold_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= LAST_R2;
            cntrl_reg <= PARK_SEL;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            cntrl_reg <= state_sel(state_next, PARK_SEL);
            busy_reg  <= (state_next != IDLE);
        end
    end

    // Grants are registered from the next state so they align with cntrl and busy
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            localparam logic [1:0] OWN_STATE = grant_state(gi);
            logic gnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    gnt_reg <= 1'b0;
                end else begin
                    gnt_reg <= (state_next == OWN_STATE);
                end
            end

            assign gnt_vec[gi] = gnt_reg;
        end
    endgenerate

    assign gnt1  = gnt_vec[0];
    assign gnt2  = gnt_vec[1];
    assign cntrl = cntrl_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_select_arbiter.sv
// Directed bench for select_arbiter: MAX_HOLD=4 and MAX_HOLD=0 instances share
// stimulus; a behavioural model fills per-instance scoreboards checked each cycle.
module tb_select_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic req1  = 1'b0;
    logic req2  = 1'b0;

    logic gnt1_a, gnt2_a, cntrl_a, busy_a;
    logic gnt1_b, gnt2_b, cntrl_b, busy_b;

    select_arbiter #(.MAX_HOLD(4), .PARK_SEL(1'b0), .CNT_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .req1(req1), .req2(req2),
        .gnt1(gnt1_a), .gnt2(gnt2_a), .cntrl(cntrl_a), .busy(busy_a)
    );

    select_arbiter #(.MAX_HOLD(0), .PARK_SEL(1'b0), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req1(req1), .req2(req2),
        .gnt1(gnt1_b), .gnt2(gnt2_b), .cntrl(cntrl_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic g1;
        logic g2;
        logic c;
        logic b;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state per instance: index 0 -> MAX_HOLD=4, index 1 -> MAX_HOLD=0
    int m_owner[2];
    int m_run[2];
    int m_last[2];
    int m_mh[2] = '{4, 0};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = 0;
            m_run[k]   = 0;
            m_last[k]  = 2;
        end
    endtask

    task automatic model_step(input int k, input logic r1, input logic r2, output exp_t e);
        int   nxt;
        logic mine;
        logic other;
        int   mh;
        mh    = m_mh[k];
        mine  = 1'b0;
        other = 1'b0;
        nxt   = 0;
        if (m_owner[k] == 0) begin
            if (r1 && r2)  nxt = (m_last[k] == 1) ? 2 : 1;
            else if (r1)   nxt = 1;
            else if (r2)   nxt = 2;
            else           nxt = 0;
        end else begin
            mine  = (m_owner[k] == 1) ? r1 : r2;
            other = (m_owner[k] == 1) ? r2 : r1;
            if (!mine)
                nxt = other ? 3 - m_owner[k] : 0;
            else if (other && mh != 0 && m_run[k] == mh - 1)
                nxt = 3 - m_owner[k];
            else
                nxt = m_owner[k];
        end
        if (nxt == 0 || nxt != m_owner[k]) m_run[k] = 0;
        else if (other && mh > 0 && m_run[k] < mh - 1) m_run[k] = m_run[k] + 1;
        if (nxt != 0 && nxt != m_owner[k]) m_last[k] = nxt;
        m_owner[k] = nxt;
        e.g1 = (nxt == 1);
        e.g2 = (nxt == 2);
        e.c  = (nxt == 2);
        e.b  = (nxt != 0);
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s @%0t observed=%0b expected=%0b", tag, $time, obs, expv);
    endtask

    task automatic compare_out(input string tag, input exp_t ea, input exp_t eb);
        check({tag, ".a.gnt1"},  gnt1_a,  ea.g1);
        check({tag, ".a.gnt2"},  gnt2_a,  ea.g2);
        check({tag, ".a.cntrl"}, cntrl_a, ea.c);
        check({tag, ".a.busy"},  busy_a,  ea.b);
        check({tag, ".a.excl"},  gnt1_a & gnt2_a, 1'b0);
        check({tag, ".b.gnt1"},  gnt1_b,  eb.g1);
        check({tag, ".b.gnt2"},  gnt2_b,  eb.g2);
        check({tag, ".b.cntrl"}, cntrl_b, eb.c);
        check({tag, ".b.busy"},  busy_b,  eb.b);
    endtask

    task automatic cycle(input logic r1, input logic r2, input string tag);
        exp_t ea;
        exp_t eb;
        req1 = r1;
        req2 = r2;
        model_step(0, r1, r2, ea);
        model_step(1, r1, r2, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(posedge clk);
        #1;
        $display("%s req=%b%b a:gnt=%b%b cntrl=%b busy=%b b:gnt=%b%b cntrl=%b busy=%b",
                 tag, r1, r2, gnt1_a, gnt2_a, cntrl_a, busy_a, gnt1_b, gnt2_b, cntrl_b, busy_b);
        compare_out(tag, q_a.pop_front(), q_b.pop_front());
    endtask

    task automatic do_reset(input string tag);
        exp_t z;
        z     = '0;
        rst_n = 1'b0;
        req1  = 1'b0;
        req2  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        $display("%s rst_n=0 a:gnt=%b%b cntrl=%b busy=%b", tag, gnt1_a, gnt2_a, cntrl_a, busy_a);
        compare_out(tag, z, z);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t z;
        z = '0;

        // Reset then idle
        do_reset("reset");
        cycle(1'b0, 1'b0, "idle0");
        cycle(1'b0, 1'b0, "idle1");

        // Single requester, then release
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, "single");
        cycle(1'b0, 1'b0, "single_rel");
        cycle(1'b0, 1'b0, "single_idle");

        // Tie after reset, then direct handoff to requester 2
        do_reset("reset_tie");
        cycle(1'b1, 1'b1, "tie");
        cycle(1'b1, 1'b1, "tie_hold");
        cycle(1'b0, 1'b1, "handoff");
        cycle(1'b0, 1'b1, "handoff_hold");
        cycle(1'b1, 1'b1, "rerequest");
        cycle(1'b0, 1'b0, "tie_rel");

        // Continuous contention: preemption on dut_a, none on dut_b
        do_reset("reset_pre");
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, "contend");
        cycle(1'b0, 1'b0, "contend_rel");

        // Mixed pseudo-random traffic
        for (int i = 0; i < 40; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");

        // Asynchronous reset while requester 2 owns the mux
        do_reset("reset_async");
        cycle(1'b0, 1'b1, "g2_enter");
        cycle(1'b1, 1'b1, "g2_hold");
        #3;
        rst_n = 1'b0;
        #1;
        $display("async_rst mid-cycle a:gnt=%b%b cntrl=%b busy=%b", gnt1_a, gnt2_a, cntrl_a, busy_a);
        compare_out("async_rst", z, z);
        model_reset();
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, "post_rst_tie");
        cycle(1'b1, 1'b1, "post_rst_hold");
        cycle(1'b0, 1'b0, "post_rst_rel");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
